// File: rtl/dfs_pkg.sv
// Shared definitions for the DFS mode controller: mode encodings, FSM states,
// default parameters and the one-step mode decision helper.
package dfs_pkg;

    localparam logic [1:0] MODE_FAST   = 2'b00;
    localparam logic [1:0] MODE_MID_HI = 2'b01;
    localparam logic [1:0] MODE_MID_LO = 2'b10;
    localparam logic [1:0] MODE_SLOW   = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } dfs_state_e;

    localparam int DEF_WIN_LOG2      = 5;
    localparam int DEF_UP_TH         = 24;
    localparam int DEF_DN_TH         = 8;
    localparam int DEF_SETTLE_CYCLES = 16;

    // Saturating single step: faster wins over slower, never wraps past the ends.
    function automatic logic [1:0] mode_step(input logic [1:0] cur,
                                             input logic       go_fast,
                                             input logic       go_slow);
        if (go_fast && cur != MODE_FAST) return cur - 2'd1;
        if (go_slow && cur != MODE_SLOW) return cur + 2'd1;
        return cur;
    endfunction

endpackage

// File: rtl/dfs_load_win.sv
// Free-running load window: counts busy cycles over 2^WIN_LOG2 cycles and
// presents the completed count on the final cycle of each window.
module dfs_load_win
    import dfs_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    output logic              win_end,
    output logic [WIN_LOG2:0] load
);

    localparam logic [WIN_LOG2-1:0] CNT_ONE = 1;

    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_LOG2:0]   acc_q, acc_d;

    // load includes the current cycle so the full window is visible at win_end.
    always_comb begin
        win_end   = &win_cnt_q;
        load      = acc_q + {{WIN_LOG2{1'b0}}, busy};
        win_cnt_d = win_cnt_q + CNT_ONE;
        acc_d     = win_end ? '0 : load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: rtl/dfs_mode_ctrl.sv
// DFS mode controller: steps the clock-source select from measured window load,
// accepts software overrides, and holds off further changes while switching.
module dfs_mode_ctrl
    import dfs_pkg::*;
#(
    parameter int WIN_LOG2      = DEF_WIN_LOG2,
    parameter int UP_TH         = DEF_UP_TH,
    parameter int DN_TH         = DEF_DN_TH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              ovr_en,
    input  logic              ovr_valid,
    input  logic [1:0]        ovr_mode,
    output logic              ovr_ready,
    output logic [1:0]        mode,
    output logic              switching,
    output logic [WIN_LOG2:0] last_load
);

    localparam logic [WIN_LOG2:0] UP_T      = (WIN_LOG2 + 1)'(UP_TH);
    localparam logic [WIN_LOG2:0] DN_T      = (WIN_LOG2 + 1)'(DN_TH);
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYCLES - 1);

    logic              win_end;
    logic [WIN_LOG2:0] load;

    dfs_load_win #(.WIN_LOG2(WIN_LOG2)) u_load_win (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .win_end (win_end),
        .load    (load)
    );

    dfs_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        settle_cnt_q, settle_cnt_d;
    logic              switching_q, switching_d;
    logic [WIN_LOG2:0] last_load_q, last_load_d;
    logic [1:0]        auto_mode;
    logic              ovr_fire;

    assign ovr_ready = (state_q == ST_IDLE) & ~rst;
    assign mode      = mode_q;
    assign switching = switching_q;
    assign last_load = last_load_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        settle_cnt_d = settle_cnt_q;
        last_load_d  = last_load_q;
        ovr_fire     = ovr_valid & ovr_ready;
        auto_mode    = mode_step(mode_q, load >= UP_T, load <= DN_T);

        if (win_end) last_load_d = load;

        unique case (state_q)
            ST_IDLE: begin
                // An accepted override always pre-empts the window decision.
                if (ovr_fire) begin
                    if (ovr_mode != mode_q) begin
                        mode_d       = ovr_mode;
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LD;
                    end
                end else if (win_end && !ovr_en && auto_mode != mode_q) begin
                    mode_d       = auto_mode;
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 8'd0) state_d = ST_IDLE;
                else                      settle_cnt_d = settle_cnt_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        switching_d = (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_FAST;
            settle_cnt_q <= '0;
            switching_q  <= 1'b0;
            last_load_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            settle_cnt_q <= settle_cnt_d;
            switching_q  <= switching_d;
            last_load_q  <= last_load_d;
        end
    end

endmodule

// File: tb/tb_dfs_mode_ctrl.sv
// Directed bench for dfs_mode_ctrl with default parameters (32-cycle window,
// thresholds 24/8, 16-cycle settle).
module tb_dfs_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst, busy, ovr_en, ovr_valid;
    logic [1:0] ovr_mode;
    logic       ovr_ready, switching;
    logic [1:0] mode;
    logic [5:0] last_load;

    int n_tests = 0;
    int n_fail  = 0;

    dfs_mode_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .ovr_en    (ovr_en),
        .ovr_valid (ovr_valid),
        .ovr_mode  (ovr_mode),
        .ovr_ready (ovr_ready),
        .mode      (mode),
        .switching (switching),
        .last_load (last_load)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with rst=0 (window cycle 0).
    task automatic do_reset();
        rst = 1'b1; busy = 1'b0; ovr_en = 1'b0; ovr_valid = 1'b0; ovr_mode = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b1; ovr_en = 1'b0; ovr_valid = 1'b1; ovr_mode = 2'b11;
        step();
        step();
        n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        n_tests++; if (switching !== 1'b0) begin n_fail++; $display("FAIL reset_switching: got %0b expected 0", switching); end
        n_tests++; if (last_load !== 6'd0) begin n_fail++; $display("FAIL reset_last_load: got %0d expected 0", last_load); end
        n_tests++; if (ovr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_ready_in_rst: got %0b expected 0", ovr_ready); end
        rst = 1'b0; ovr_valid = 1'b0; busy = 1'b0;
        #1;
        n_tests++; if (ovr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ovr_ready_after: got %0b expected 1", ovr_ready); end
    endtask

    task automatic test_full_busy();
        do_reset();
        busy = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) begin
                step();
                n_tests++; if (switching !== 1'b0) begin n_fail++; $display("FAIL full_busy_switching w%0d i%0d: got %0b expected 0", w, i, switching); end
            end
            n_tests++; if (last_load !== 6'd32) begin n_fail++; $display("FAIL full_busy_last_load w%0d: got %0d expected 32", w, last_load); end
            n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL full_busy_mode w%0d: got %0d expected 0", w, mode); end
        end
        busy = 1'b0;
    endtask

    task automatic test_idle_steps();
        logic [1:0] exp_mode;
        logic       exp_sw;
        do_reset();
        for (int cyc = 1; cyc <= 130; cyc++) begin
            step();
            exp_mode = (cyc < 32) ? 2'd0 : (cyc < 64) ? 2'd1 : (cyc < 96) ? 2'd2 : 2'd3;
            exp_sw   = (cyc >= 32 && cyc < 48) || (cyc >= 64 && cyc < 80) || (cyc >= 96 && cyc < 112);
            n_tests++; if (mode !== exp_mode) begin n_fail++; $display("FAIL idle_mode c%0d: got %0d expected %0d", cyc, mode, exp_mode); end
            n_tests++; if (switching !== exp_sw) begin n_fail++; $display("FAIL idle_switching c%0d: got %0b expected %0b", cyc, switching, exp_sw); end
        end
    endtask

    // Uses an override in window 1 (auto disabled) to reach a starting mode.
    task automatic preset_mode(input logic [1:0] m);
        do_reset();
        ovr_en = 1'b1; ovr_valid = 1'b1; ovr_mode = m;
        step();
        ovr_valid = 1'b0;
        repeat (31) step();
        ovr_en = 1'b0;
        n_tests++; if (mode !== m) begin n_fail++; $display("FAIL preset_mode: got %0d expected %0d", mode, m); end
    endtask

    task automatic run_window(input int n_busy);
        for (int i = 0; i < 32; i++) begin
            busy = (i < n_busy);
            step();
        end
        busy = 1'b0;
    endtask

    task automatic test_half_load();
        preset_mode(2'b10);
        for (int w = 0; w < 2; w++) begin
            run_window(16);
            n_tests++; if (last_load !== 6'd16) begin n_fail++; $display("FAIL half_last_load w%0d: got %0d expected 16", w, last_load); end
            n_tests++; if (mode !== 2'b10) begin n_fail++; $display("FAIL half_mode w%0d: got %0d expected 2", w, mode); end
            n_tests++; if (switching !== 1'b0) begin n_fail++; $display("FAIL half_switching w%0d: got %0b expected 0", w, switching); end
        end
    endtask

    task automatic test_thresholds();
        int         loads [5] = '{23, 9, 24, 24, 8};
        logic [1:0] emode [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic       esw   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        preset_mode(2'b01);
        for (int w = 0; w < 5; w++) begin
            run_window(loads[w]);
            n_tests++; if (last_load !== 6'(loads[w])) begin n_fail++; $display("FAIL thr_last_load w%0d: got %0d expected %0d", w, last_load, loads[w]); end
            n_tests++; if (mode !== emode[w]) begin n_fail++; $display("FAIL thr_mode w%0d: got %0d expected %0d", w, mode, emode[w]); end
            n_tests++; if (switching !== esw[w]) begin n_fail++; $display("FAIL thr_switching w%0d: got %0b expected %0b", w, switching, esw[w]); end
        end
    endtask

    task automatic test_override();
        do_reset();
        ovr_en = 1'b1; ovr_valid = 1'b1; ovr_mode = 2'b10;
        #1;
        n_tests++; if (ovr_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready_idle: got %0b expected 1", ovr_ready); end
        step();
        n_tests++; if (mode !== 2'b10) begin n_fail++; $display("FAIL ovr_mode_applied: got %0d expected 2", mode); end
        n_tests++; if (switching !== 1'b1) begin n_fail++; $display("FAIL ovr_switching: got %0b expected 1", switching); end
        ovr_mode = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            n_tests++; if (ovr_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_ready_settle k%0d: got %0b expected 0", k, ovr_ready); end
            n_tests++; if (mode !== 2'b10) begin n_fail++; $display("FAIL ovr_mode_frozen k%0d: got %0d expected 2", k, mode); end
            step();
        end
        n_tests++; if (ovr_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_ready_last_settle: got %0b expected 0", ovr_ready); end
        step();
        n_tests++; if (ovr_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready_back_idle: got %0b expected 1", ovr_ready); end
        n_tests++; if (mode !== 2'b10) begin n_fail++; $display("FAIL ovr_mode_before_held: got %0d expected 2", mode); end
        step();
        n_tests++; if (mode !== 2'b01) begin n_fail++; $display("FAIL ovr_held_accepted: got %0d expected 1", mode); end
        n_tests++; if (switching !== 1'b1) begin n_fail++; $display("FAIL ovr_held_switching: got %0b expected 1", switching); end
        ovr_valid = 1'b0;
        repeat (16) step();
        ovr_valid = 1'b1; ovr_mode = 2'b01;
        step();
        ovr_valid = 1'b0;
        n_tests++; if (mode !== 2'b01) begin n_fail++; $display("FAIL ovr_same_mode: got %0d expected 1", mode); end
        n_tests++; if (switching !== 1'b0) begin n_fail++; $display("FAIL ovr_same_switching: got %0b expected 0", switching); end
        n_tests++; if (ovr_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_same_ready: got %0b expected 1", ovr_ready); end
    endtask

    task automatic test_collision();
        preset_mode(2'b01);
        busy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin ovr_valid = 1'b1; ovr_mode = 2'b11; end
            step();
        end
        ovr_valid = 1'b0; busy = 1'b0;
        n_tests++; if (mode !== 2'b11) begin n_fail++; $display("FAIL collide_mode: got %0d expected 3", mode); end
        n_tests++; if (switching !== 1'b1) begin n_fail++; $display("FAIL collide_switching: got %0b expected 1", switching); end
        n_tests++; if (last_load !== 6'd32) begin n_fail++; $display("FAIL collide_last_load: got %0d expected 32", last_load); end
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        ovr_en = 1'b1; ovr_valid = 1'b1; ovr_mode = 2'b10;
        step();
        ovr_valid = 1'b0;
        repeat (4) step();
        n_tests++; if (switching !== 1'b1) begin n_fail++; $display("FAIL mid_settle_pre: got %0b expected 1", switching); end
        rst = 1'b1;
        step();
        n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL mid_rst_mode: got %0d expected 0", mode); end
        n_tests++; if (switching !== 1'b0) begin n_fail++; $display("FAIL mid_rst_switching: got %0b expected 0", switching); end
        rst = 1'b0; ovr_en = 1'b0;
        #1;
        n_tests++; if (ovr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %0b expected 1", ovr_ready); end
        repeat (31) step();
        n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL post_rst_window_early: got %0d expected 0", mode); end
        step();
        n_tests++; if (mode !== 2'b01) begin n_fail++; $display("FAIL post_rst_window_step: got %0d expected 1", mode); end
    endtask

    initial begin
        test_reset();
        test_full_busy();
        test_idle_steps();
        test_half_load();
        test_thresholds();
        test_override();
        test_collision();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dfs_mode_ctrl.md
DFS_MODE_CTRL -- requirements
Module: dfs_mode_ctrl

Interface
REQ-001 Parameter WIN_LOG2, default 5; load-measurement window is 2^WIN_LOG2 cycles.
REQ-002 Parameter UP_TH, default 24; window load at or above this value requests a faster clock.
REQ-003 Parameter DN_TH, default 8; window load at or below this value requests a slower clock (DN_TH < UP_TH).
REQ-004 Parameter SETTLE_CYCLES, default 16; hold-off after any mode change, range 1..255.
REQ-005 Port clk, input, 1; single clock, all state rising-edge.
REQ-006 Port rst, input, 1; reset, synchronous, active-high.
REQ-007 Port busy, input, 1; activity strobe, one count per cycle high.
REQ-008 Port ovr_en, input, 1; when 1, automatic decisions are disabled.
REQ-009 Port ovr_valid, input, 1; override request strobe.
REQ-010 Port ovr_mode, input, 2; requested mode.
REQ-011 Port ovr_ready, output, 1; override is accepted when ovr_valid & ovr_ready.
REQ-012 Port mode, output, 2; drives the clock-switch select: 00 selects the fastest source, 11 the slowest.
REQ-013 Port switching, output, 1; high while the controller is in SETTLE.
REQ-014 Port last_load, output, WIN_LOG2+1; busy count of the last completed window.

Function
REQ-015 Window counter SHALL run freely 0..2^WIN_LOG2-1 and wrap, independent of state and ovr_en.
REQ-016 Accumulator SHALL add busy every cycle; window-end load = acc + busy on the final cycle; acc clears to 0 at the next edge; width WIN_LOG2+1, so no overflow.
REQ-017 last_load SHALL register the window-end load at the edge ending each window.
REQ-018 FSM states: IDLE and SETTLE only.
REQ-019 In IDLE at window end with ovr_en=0: if load>=UP_TH and mode!=00, mode <= mode-1; else if load<=DN_TH and mode!=11, mode <= mode+1; otherwise no change.
REQ-020 A load at UP_TH with mode 00, or at DN_TH with mode 11, SHALL produce no change and no SETTLE entry.
REQ-021 Mode SHALL move at most one step per automatic decision; it never wraps.
REQ-022 ovr_ready SHALL equal (state==IDLE) & ~rst, combinationally.
REQ-023 On override handshake: if ovr_mode!=mode, mode <= ovr_mode at the same edge and the FSM enters SETTLE; if equal, the request is consumed with no change.
REQ-024 An override handshake and an automatic decision in the same cycle: the override wins and the automatic decision is discarded.
REQ-025 Any mode change SHALL enter SETTLE for exactly SETTLE_CYCLES cycles, with switching=1 in each; the FSM then returns to IDLE.
REQ-026 In SETTLE, window-end decisions are discarded, mode is frozen, and ovr_ready=0.
REQ-027 Latency: a decision cycle produces the new mode and switching=1 in the following cycle.

Reset
REQ-028 While rst=1 at an edge: mode=00, state=IDLE, switching=0, last_load=0, window counter=0, accumulator=0, settle counter=0.
REQ-029 Reset asserted mid-SETTLE or mid-window SHALL abort the operation with no partial decision; the first window after reset starts on the first cycle with rst=0.

Structure
REQ-030 Shared package dfs_pkg SHALL hold the mode encodings (MODE_FAST=00 .. MODE_SLOW=11), the state enum, and default parameter constants.
REQ-031 Window counter and accumulator SHALL be one sub-module, dfs_load_win, outputting win_end and load; the FSM stays in dfs_mode_ctrl.

Verification
REQ-032 Reset, then busy=1 constantly -> last_load=32 after each window; mode stays 00; switching never asserts.
REQ-033 Reset, then busy=0 constantly -> mode steps 01, 10, 11 at cycles 33, 65 and 97 after reset release, then holds at 11; switching is high for 16 cycles after each step.
REQ-034 busy high 16 of every 32 cycles starting from mode 10 -> last_load=16, no mode change.
REQ-035 In IDLE, ovr_valid=1 with ovr_mode=10 -> mode=10 next cycle and ovr_ready=0 for 16 cycles; a request held across SETTLE is accepted on the first IDLE cycle.
REQ-036 Override handshake with ovr_mode=11 in the same cycle as a window end with load=32 at mode 01 -> mode=11, not 00.
REQ-037 rst pulsed at cycle 5 of SETTLE -> next cycle mode=00, switching=0, ovr_ready=1 after rst drops.
